rv32i_exec_core: RTL and testbench
==================================

# rv32i_exec_core

Execute-stage datapath core for the 5-stage RV32I pipeline. It combines the immediate generator, which decodes a sign-extended immediate from the instruction word, with the integer ALU, which produces the arithmetic/logic/shift result and the branch-taken decision. Both are combinational, followed by an optional registered copy of the result for the execute/memory boundary. The pipeline drives operand muxing (PC vs rs1, rs2 vs imm vs 4) outside this block.

## Interface
- No parameters.
- clk  in  1  system clock; rising-edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction word in execute stage (NOP = 32'h0000_0033).
- in_a  in  32  ALU operand A.
- in_b  in  32  ALU operand B.
- en  in  1  capture enable for registered outputs.
- imm  out  32  decoded immediate (combinational).
- result  out  32  ALU result (combinational).
- take_b  out  1  branch condition true (combinational).
- result_q  out  32  registered result.
- take_b_q  out  1  registered take_b.

## Operation

**Immediate decode** (opcode = instr[6:0]):
- I-type (0000011 load, 0010011 op-imm, 1100111 JALR, 1110011 SYSTEM): {{21{i[31]}}, i[30:20]}.
- S-type (0100011): {{21{i[31]}}, i[30:25], i[11:7]}.
- B-type (1100011): {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}.
- U-type (0110111 LUI, 0010111 AUIPC): {i[31:12], 12'b0}.
- J-type (1101111): {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
- Any other opcode: 0.

**ALU ops** (f3 = instr[14:12], b30 = instr[30]):

For R-type (0110033 opcode 0110011) and op-imm (0010011):
- 000: ADD, or SUB when R-type and b30=1. ADDI never subtracts.
- 001: SLL by in_b[4:0].
- 010: SLT, signed; result 1 or 0.
- 011: SLTU, unsigned.
- 100: XOR.
- 101: SRL, or SRA when b30=1 (both R and I forms); shift amount is in_b[4:0].
- 110: OR.
- 111: AND.

All other opcodes (JAL, JALR, AUIPC, load, store, branch, LUI, SYSTEM):
- result = in_a + in_b, mod 2^32.
- f3 is ignored, since these bits may be immediate bits.

**take_b**: asserted only when opcode = 1100011; otherwise 0. Conditions:
- BEQ 000: a==b.
- BNE 001: a!=b.
- BLT 100: signed a<b.
- BGE 101: signed a>=b.
- BLTU 110: unsigned a<b.
- BGEU 111: unsigned a>=b.
- f3 010/011: 0.

**Arithmetic rules**
- Addition and subtraction wrap silently; no overflow flag.
- Shift amounts greater than 31 are impossible because only 5 bits are used.

## Timing
- imm, result and take_b are purely combinational from instr, in_a and in_b; zero latency.
- On each rising clk edge:
  - reset=1: result_q←0, take_b_q←0. Reset has priority over en.
  - else en=1: result_q←result, take_b_q←take_b.
  - else: hold.
- Reset mid-operation clears the registers on that edge; combinational outputs are unaffected by reset.
- Registered outputs are valid one cycle after capture.

## Test plan
- ADD/SUB: instr=32'h0020_81B3 (add), a=7, b=5 → result=12. instr=32'h4020_81B3 (sub), a=5, b=7 → result=32'hFFFF_FFFE. take_b=0.
- Shifts/compares: SRA a=32'h8000_0000, b=4 → 32'hF800_0000. SRL same → 32'h0800_0000. SRAI (instr bit30=1, op-imm) matches SRA. SLT a=-1, b=1 → 1. SLTU same → 0.
- Immediates: addi x1,x0,-1 (32'hFFF0_0093) → imm=32'hFFFF_FFFF. lui x1,0x12345 → imm=32'h1234_5000. jal offset -4 (32'hFFDF_F0EF) → imm=32'hFFFF_FFFC. sw with offset 8 → imm=8.
- Branches: BEQ a=b=3 → take_b=1. BLT a=-2, b=1 → 1. BLTU a=-2, b=1 → 0. BGEU a=b → 1. Non-branch op with a=b → take_b=0.
- Non-ALU opcodes: JAL with a=32'h100, b=4 → result=32'h104, regardless of f3 bits. Unknown opcode → imm=0.
- Registers:
  - reset=1 with en=1 → result_q=0, take_b_q=0.
  - Release reset, en=1, add 2+3 → result_q=5 after the edge.
  - en=0 with inputs changed → result_q holds 5.

Source files
------------

// File: rtl/rv32i_exec_core.sv
// rv32i_exec_core: execute-stage immediate decode, integer ALU,
// branch compare and optional registered result for EX/MEM.
module rv32i_exec_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        en,
  output logic [31:0] imm,
  output logic [31:0] result,
  output logic        take_b,
  output logic [31:0] result_q,
  output logic        take_b_q
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        b30;
  logic [4:0]  shamt;

  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic        is_reg;
  logic        is_opimm;

  logic        eq;
  logic        lt_s;
  logic        lt_u;
  logic [31:0] sum;
  logic [31:0] diff;

  logic [31:0] result_d;
  logic        take_b_d;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign b30    = instr[30];
  assign shamt  = in_b[4:0];

  // Classify the opcode into immediate formats and ALU classes.
  always_comb begin
    is_reg   = (opcode == OP_REG);
    is_opimm = (opcode == OP_IMM);
    is_i     = (opcode == OP_LOAD)  ||
               (opcode == OP_IMM)   ||
               (opcode == OP_JALR)  ||
               (opcode == OP_SYSTEM);
    is_s     = (opcode == OP_STORE);
    is_b     = (opcode == OP_BRANCH);
    is_u     = (opcode == OP_LUI) ||
               (opcode == OP_AUIPC);
    is_j     = (opcode == OP_JAL);
  end

  // Sign-extended immediate for the decoded format.
  always_comb begin
    imm = 32'h0;
    unique case (1'b1)
      is_i: imm = {{21{instr[31]}},
                   instr[30:20]};
      is_s: imm = {{21{instr[31]}},
                   instr[30:25],
                   instr[11:7]};
      is_b: imm = {{20{instr[31]}},
                   instr[7],
                   instr[30:25],
                   instr[11:8],
                   1'b0};
      is_u: imm = {instr[31:12],
                   12'h000};
      is_j: imm = {{12{instr[31]}},
                   instr[19:12],
                   instr[20],
                   instr[30:21],
                   1'b0};
      default: imm = 32'h0;
    endcase
  end

  // Shared adder, subtractor and comparators.
  always_comb begin
    sum  = in_a + in_b;
    diff = in_a - in_b;
    eq   = (in_a == in_b);
    lt_u = (in_a < in_b);
    lt_s = ($signed(in_a) < $signed(in_b));
  end

  // ALU result; only R-type and op-imm honour f3.
  always_comb begin
    result = sum;
    if (is_reg || is_opimm) begin
      unique case (f3)
        3'b000: result = (is_reg && b30)
                         ? diff : sum;
        3'b001: result = in_a << shamt;
        3'b010: result = {31'h0, lt_s};
        3'b011: result = {31'h0, lt_u};
        3'b100: result = in_a ^ in_b;
        3'b101: result = b30
          ? 32'($signed(in_a) >>> shamt)
          : in_a >> shamt;
        3'b110: result = in_a | in_b;
        3'b111: result = in_a & in_b;
        default: result = sum;
      endcase
    end
  end

  // Branch decision, only for conditional branches.
  always_comb begin
    take_b = 1'b0;
    if (is_b) begin
      unique case (f3)
        3'b000: take_b = eq;
        3'b001: take_b = !eq;
        3'b100: take_b = lt_s;
        3'b101: take_b = !lt_s;
        3'b110: take_b = lt_u;
        3'b111: take_b = !lt_u;
        default: take_b = 1'b0;
      endcase
    end
  end

  // Next-state for the EX/MEM copy: capture on en, else hold.
  always_comb begin
    result_d = result_q;
    take_b_d = take_b_q;
    if (en) begin
      result_d = result;
      take_b_d = take_b;
    end
  end

  // EX/MEM registers; reset wins over en.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'h0;
      take_b_q <= 1'b0;
    end else begin
      result_q <= result_d;
      take_b_q <= take_b_d;
    end
  end

endmodule

// File: tb/tb_rv32i_exec_core.sv
// tb_rv32i_exec_core: directed and randomized checks of the
// execute core against a reference model of the ISA rules.
module tb_rv32i_exec_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        en;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;
  logic [31:0] result_q;
  logic        take_b_q;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] exp_rq;
  logic        exp_tq;

  always #5 clk = ~clk;

  rv32i_exec_core dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .in_a     (in_a),
    .in_b     (in_b),
    .en       (en),
    .imm      (imm),
    .result   (result),
    .take_b   (take_b),
    .result_q (result_q),
    .take_b_q (take_b_q)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    instr = i;
    in_a  = a;
    in_b  = b;
    #1;
  endtask

  function automatic logic [31:0] r_ins(
      input logic [6:0] f7, input logic [2:0] fn);
    return {f7, 5'd2, 5'd1, fn, 5'd3, 7'h33};
  endfunction

  function automatic logic [31:0] i_ins(
      input logic [11:0] im, input logic [2:0] fn);
    return {im, 5'd1, fn, 5'd3, 7'h13};
  endfunction

  function automatic logic [31:0] b_ins(
      input logic [2:0] fn);
    return {7'h0, 5'd2, 5'd1, fn, 5'h0, 7'h63};
  endfunction

  // Reference immediate: reassemble the ISA bit fields as a
  // signed offset value.
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic [31:0] v;
    int signed s;
    v = i;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        s = $signed(v) >>> 20;
        return 32'(s);
      end
      7'h23: begin
        s = ($signed(v) >>> 25) * 32 + int'(v[11:7]);
        return 32'(s);
      end
      7'h63: begin
        s = ($signed(v) >>> 31) * 4096 + int'(v[7]) * 2048
          + int'(v[30:25]) * 32 + int'(v[11:8]) * 2;
        return 32'(s);
      end
      7'h37, 7'h17: return v & 32'hFFFF_F000;
      7'h6F: begin
        s = ($signed(v) >>> 31) * (1 << 20)
          + int'(v[19:12]) * 4096 + int'(v[20]) * 2048
          + int'(v[30:21]) * 2;
        return 32'(s);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_res(input logic [31:0] i,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    int signed sa, sb;
    bit alu;
    sh = b % 32;
    sa = $signed(a);
    sb = $signed(b);
    alu = (i[6:0] == 7'h33) || (i[6:0] == 7'h13);
    if (!alu) return a + b;
    case (i[14:12])
      3'd0: return (i[6:0] == 7'h33 && i[30]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return i[30] ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic m_take(input logic [31:0] i,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    int signed sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (i[6:0] != 7'h63) return 1'b0;
    case (i[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [6:0] ops [12];
    logic [31:0] ri, ra, rb;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};

    reset = 1'b1;
    en    = 1'b1;
    instr = 32'h0000_0033;
    in_a  = 32'h1234_5678;
    in_b  = 32'h1;

    // Reset with en high clears the registers.
    @(posedge clk);
    #1;
    chk("rst_result_q", result_q, 32'h0);
    chk("rst_take_b_q", {31'h0, take_b_q}, 32'h0);

    en = 1'b0;
    reset = 1'b0;

    drive(32'h0020_81B3, 32'd7, 32'd5);
    chk("add", result, 32'd12);
    chk("add_tb", {31'h0, take_b}, 32'h0);
    drive(32'h4020_81B3, 32'd5, 32'd7);
    chk("sub", result, 32'hFFFF_FFFE);
    drive(r_ins(7'h20, 3'd5), 32'h8000_0000, 32'd4);
    chk("sra", result, 32'hF800_0000);
    drive(r_ins(7'h00, 3'd5), 32'h8000_0000, 32'd4);
    chk("srl", result, 32'h0800_0000);
    drive(i_ins(12'h404, 3'd5), 32'h8000_0000, 32'd4);
    chk("srai", result, 32'hF800_0000);
    drive(i_ins(12'h400, 3'd0), 32'd5, 32'd7);
    chk("addi_nosub", result, 32'd12);
    drive(r_ins(7'h00, 3'd2), 32'hFFFF_FFFF, 32'd1);
    chk("slt", result, 32'd1);
    drive(r_ins(7'h00, 3'd3), 32'hFFFF_FFFF, 32'd1);
    chk("sltu", result, 32'd0);

    drive(32'hFFF0_0093, 32'd0, 32'd0);
    chk("imm_addi", imm, 32'hFFFF_FFFF);
    drive(32'h1234_50B7, 32'd0, 32'd0);
    chk("imm_lui", imm, 32'h1234_5000);
    drive(32'hFFDF_F0EF, 32'h100, 32'd4);
    chk("imm_jal", imm, 32'hFFFF_FFFC);
    chk("jal_res", result, 32'h104);
    drive({7'h0, 5'd2, 5'd1, 3'b010, 5'd8, 7'h23},
          32'd0, 32'd0);
    chk("imm_sw", imm, 32'd8);
    drive(32'hFFFF_FFFF, 32'd1, 32'd2);
    chk("imm_unk", imm, 32'h0);

    drive(b_ins(3'd0), 32'd3, 32'd3);
    chk("beq", {31'h0, take_b}, 32'd1);
    drive(b_ins(3'd4), 32'hFFFF_FFFE, 32'd1);
    chk("blt", {31'h0, take_b}, 32'd1);
    drive(b_ins(3'd6), 32'hFFFF_FFFE, 32'd1);
    chk("bltu", {31'h0, take_b}, 32'd0);
    drive(b_ins(3'd7), 32'd9, 32'd9);
    chk("bgeu", {31'h0, take_b}, 32'd1);
    drive(b_ins(3'd2), 32'd9, 32'd9);
    chk("b_f3_010", {31'h0, take_b}, 32'd0);
    drive(32'h0020_81B3, 32'd9, 32'd9);
    chk("nonbr_tb", {31'h0, take_b}, 32'd0);

    // Capture, then hold with en low.
    drive(32'h0020_81B3, 32'd2, 32'd3);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("cap_result_q", result_q, 32'd5);
    drive(32'h0020_81B3, 32'd40, 32'd3);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_result_q", result_q, 32'd5);
    exp_rq = 32'd5;
    exp_tq = 1'b0;

    // Randomized instructions, operands, en and reset.
    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 11)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0)
        rb = {27'h0, rb[4:0]};
      drive(ri, ra, rb);
      en    = $urandom_range(0, 1);
      reset = ($urandom_range(0, 15) == 0);
      chk("rnd_imm", imm, m_imm(ri));
      chk("rnd_res", result, m_res(ri, ra, rb));
      chk("rnd_tb", {31'h0, take_b},
          {31'h0, m_take(ri, ra, rb)});
      if (reset) begin
        exp_rq = 32'h0;
        exp_tq = 1'b0;
      end else if (en) begin
        exp_rq = m_res(ri, ra, rb);
        exp_tq = m_take(ri, ra, rb);
      end
      @(posedge clk);
      #1;
      chk("rnd_result_q", result_q, exp_rq);
      chk("rnd_take_b_q", {31'h0, take_b_q},
          {31'h0, exp_tq});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
